// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Provides the register index/data widths, the register count, the grant
// encoding and the packed FIFO entry layout, plus a one-hot register decoder
// used to build the pending-write mask.
package regfile_wb_arbiter_pkg;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned EW       = AW + DW;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  // One-hot decode of a destination register; register 0 never shows as pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [AW-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    m[0]  = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback sources / register file and the arbiter.
//   flush                      : drop everything queued in both FIFOs
//   a_valid/a_ready/a_reg/a_data : source A (ALU) push handshake
//   b_valid/b_ready/b_reg/b_data : source B (load/multicycle) push handshake
//   rf_writereg/rf_writedata/rf_regwrite : register-file write port
//   pending_mask               : destinations with an in-flight write
// master: the surrounding pipeline; slave: the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                flush;
  logic                a_valid;
  logic                a_ready;
  logic [AW-1:0]       a_reg;
  logic [DW-1:0]       a_data;
  logic                b_valid;
  logic                b_ready;
  logic [AW-1:0]       b_reg;
  logic [DW-1:0]       b_data;
  logic [AW-1:0]       rf_writereg;
  logic [DW-1:0]       rf_writedata;
  logic                rf_regwrite;
  logic [NUM_REGS-1:0] pending_mask;

  modport master (
    output flush,
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  rf_writereg, rf_writedata, rf_regwrite,
    input  pending_mask
  );

  modport slave (
    input  flush,
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output rf_writereg, rf_writedata, rf_regwrite,
    output pending_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small per-source writeback FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empty the FIFO; a same-edge push is dropped
//   push/entry_in: write request (ignored when full)
//   pop          : remove head (ignored when empty)
//   head         : current head entry
//   full/empty   : occupancy flags
//   entry_valid/entry_rd : per-slot valid bit and destination, for mask building
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  wb_entry_t                  entry_in,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH-1:0][AW-1:0]   entry_rd
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          do_push;
  logic          do_pop;
  wb_entry_t     mem [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[IW-1:0]];

  // Pointer update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[IW-1:0]] <= entry_in;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, IW'(IW'(i) - rd_ptr[IW-1:0])} < count;
      entry_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between source A (ALU) and
// source B (load/multicycle). Each source queues into its own FIFO; a
// round-robin arbiter pops one entry per cycle into a registered write stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of regfile_wb_arbiter_if (handshakes, flush,
//                register-file write port, pending_mask)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  wb_entry_t                 a_in;
  wb_entry_t                 b_in;
  wb_entry_t                 a_head;
  wb_entry_t                 b_head;
  wb_entry_t                 pop_entry;
  logic                      a_full;
  logic                      a_empty;
  logic                      b_full;
  logic                      b_empty;
  logic                      a_pop;
  logic                      b_pop;
  logic [DEPTH-1:0]          a_ev;
  logic [DEPTH-1:0]          b_ev;
  logic [DEPTH-1:0][AW-1:0]  a_rd;
  logic [DEPTH-1:0][AW-1:0]  b_rd;
  grant_e                    last_grant;
  logic [AW-1:0]             wr_reg;
  logic [DW-1:0]             wr_data;
  logic                      wr_en;
  logic [NUM_REGS-1:0]       mask;

  assign a_in = '{rd: bus.a_reg, data: bus.a_data};
  assign b_in = '{rd: bus.b_reg, data: bus.b_data};

  // Ready reflects occupancy only, so a full FIFO refuses even if it pops this edge.
  assign bus.a_ready = !a_full;
  assign bus.b_ready = !b_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush),
    .push        (bus.a_valid),
    .entry_in    (a_in),
    .pop         (a_pop),
    .head        (a_head),
    .full        (a_full),
    .empty       (a_empty),
    .entry_valid (a_ev),
    .entry_rd    (a_rd)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush),
    .push        (bus.b_valid),
    .entry_in    (b_in),
    .pop         (b_pop),
    .head        (b_head),
    .full        (b_full),
    .empty       (b_empty),
    .entry_valid (b_ev),
    .entry_rd    (b_rd)
  );

  // Round-robin grant: on contention the source not granted last time wins.
  always_comb begin
    a_pop     = 1'b0;
    b_pop     = 1'b0;
    pop_entry = a_head;
    if (!bus.flush) begin
      if (!a_empty && (b_empty || last_grant == GRANT_B)) begin
        a_pop = 1'b1;
      end else if (!b_empty) begin
        b_pop     = 1'b1;
        pop_entry = b_head;
      end
    end
  end

  // Registered write stage; a register-0 entry is consumed without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_B;
      wr_en      <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
    end else if (a_pop || b_pop) begin
      last_grant <= a_pop ? GRANT_A : GRANT_B;
      wr_en      <= (pop_entry.rd != '0);
      wr_reg     <= pop_entry.rd;
      wr_data    <= pop_entry.data;
    end else begin
      wr_en      <= 1'b0;
    end
  end

  assign bus.rf_regwrite  = wr_en;
  assign bus.rf_writereg  = wr_reg;
  assign bus.rf_writedata = wr_data;

  // Pending mask covers every live FIFO slot plus the write being issued now.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a_ev[i]) mask = mask | reg_onehot(a_rd[i]);
      if (b_ev[i]) mask = mask | reg_onehot(b_rd[i]);
    end
    if (wr_en) mask = mask | reg_onehot(wr_reg);
  end

  assign bus.pending_mask = mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Source stimulus queues, reference FIFO contents and expected writes.
  wb_entry_t stim_a[$];
  wb_entry_t stim_b[$];
  wb_entry_t mq_a[$];
  wb_entry_t mq_b[$];
  wb_entry_t exp_q[$];
  logic [AW-1:0] seen[$];

  bit            m_last_b   = 1'b1;
  bit            m_out_v    = 1'b0;
  logic [AW-1:0] m_out_reg  = '0;
  logic [DW-1:0] m_out_data = '0;

  bit a_hold   = 1'b0;
  bit b_hold   = 1'b0;
  bit gaps     = 1'b0;
  bit rand_ctl = 1'b0;
  bit chk_en   = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue-level behaviour advanced at each rising edge.
  always @(posedge clk) begin : model
    bit acc_a;
    bit acc_b;
    bit pa;
    bit pb;
    wb_entry_t e;
    if (reset) begin
      mq_a.delete();
      mq_b.delete();
      m_last_b   = 1'b1;
      m_out_v    = 1'b0;
      m_out_reg  = '0;
      m_out_data = '0;
    end else if (bus.flush) begin
      mq_a.delete();
      mq_b.delete();
      m_out_v = 1'b0;
    end else begin
      acc_a = bus.a_valid && (mq_a.size() < DEPTH);
      acc_b = bus.b_valid && (mq_b.size() < DEPTH);
      pa = (mq_a.size() > 0) && ((mq_b.size() == 0) || m_last_b);
      pb = !pa && (mq_b.size() > 0);
      m_out_v = 1'b0;
      if (pa || pb) begin
        e = pa ? mq_a.pop_front() : mq_b.pop_front();
        m_out_reg  = e.rd;
        m_out_data = e.data;
        m_out_v    = (e.rd != 0);
        if (m_out_v) exp_q.push_back(e);
        m_last_b = pb;
      end
      if (acc_a) begin
        mq_a.push_back('{rd: bus.a_reg, data: bus.a_data});
        stim_a.delete(0);
        a_hold = 1'b0;
      end
      if (acc_b) begin
        mq_b.push_back('{rd: bus.b_reg, data: bus.b_data});
        stim_b.delete(0);
        b_hold = 1'b0;
      end
    end
  end

  // Monitor: compare DUT outputs with the model and pop the scoreboard on each write.
  always @(negedge clk) begin : monitor
    logic [NUM_REGS-1:0] em;
    wb_entry_t e;
    if (chk_en) begin
      em = '0;
      foreach (mq_a[i]) if (mq_a[i].rd != 0) em[mq_a[i].rd] = 1'b1;
      foreach (mq_b[i]) if (mq_b[i].rd != 0) em[mq_b[i].rd] = 1'b1;
      if (m_out_v) em[m_out_reg] = 1'b1;
      check("a_ready", 64'(bus.a_ready), 64'(mq_a.size() < DEPTH));
      check("b_ready", 64'(bus.b_ready), 64'(mq_b.size() < DEPTH));
      check("pending_mask", 64'(bus.pending_mask), 64'(em));
      check("rf_regwrite", 64'(bus.rf_regwrite), 64'(m_out_v));
      check("rf_writereg_hold", 64'(bus.rf_writereg), 64'(m_out_reg));
      check("rf_writedata_hold", 64'(bus.rf_writedata), 64'(m_out_data));
      if (bus.rf_regwrite === 1'b1) begin
        seen.push_back(bus.rf_writereg);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_write: got reg %0d with nothing expected at %0t",
                   bus.rf_writereg, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_reg", 64'(bus.rf_writereg), 64'(e.rd));
          check("sb_data", 64'(bus.rf_writedata), 64'(e.data));
        end
      end
    end
  end

  // Source drivers: hold valid/reg/data stable until the model records acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (stim_a.size() == 0) a_hold = 1'b0;
      else if (!a_hold && (!gaps || $urandom_range(3) != 0)) a_hold = 1'b1;
      if (stim_b.size() == 0) b_hold = 1'b0;
      else if (!b_hold && (!gaps || $urandom_range(3) != 0)) b_hold = 1'b1;
      bus.a_valid = a_hold;
      bus.b_valid = b_hold;
      if (a_hold) begin
        bus.a_reg  = stim_a[0].rd;
        bus.a_data = stim_a[0].data;
      end else begin
        bus.a_reg  = AW'($urandom);
        bus.a_data = $urandom;
      end
      if (b_hold) begin
        bus.b_reg  = stim_b[0].rd;
        bus.b_data = stim_b[0].data;
      end else begin
        bus.b_reg  = AW'($urandom);
        bus.b_data = $urandom;
      end
      if (rand_ctl) begin
        bus.flush = ($urandom_range(63) == 0);
        reset     = ($urandom_range(199) == 0);
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((stim_a.size() != 0 || stim_b.size() != 0 || mq_a.size() != 0 ||
            mq_b.size() != 0 || m_out_v || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic push_a(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    stim_a.push_back('{rd: rd, data: d});
  endtask

  task automatic push_b(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    stim_b.push_back('{rd: rd, data: d});
  endtask

  initial begin
    logic [AW-1:0] order [8];
    order = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_reg = '0;
    bus.b_reg = '0;
    bus.a_data = '0;
    bus.b_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single write through A.
    push_a(5'd5, 32'h0000_00AA);
    wait_drain("single", 50);

    // Register-0 write through B: consumed, never written, leaves last grant on B.
    push_b(5'd0, 32'hDEAD_BEEF);
    wait_drain("reg0", 50);

    // Contention: both sources burst four entries, writes must alternate A/B.
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      push_a(AW'(1 + i), $urandom);
      push_b(AW'(11 + i), $urandom);
    end
    wait_drain("contention", 100);
    check("contention_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) check("contention_order", 64'(seen[i]), 64'(order[i]));
    end

    // A-only burst: FIFO never fills, one write per cycle.
    for (int i = 0; i < 6; i++) push_a(AW'(20 + i), $urandom);
    wait_drain("a_burst", 100);

    // Flush with both FIFOs loaded.
    for (int i = 0; i < 4; i++) begin
      push_a(AW'(6 + i), $urandom);
      push_b(AW'(16 + i), $urandom);
    end
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    stim_a.delete();
    stim_b.delete();
    @(negedge clk);
    bus.flush = 1'b0;
    wait_drain("flush", 50);

    // Reset mid-stream, then first contention must grant A.
    for (int i = 0; i < 4; i++) begin
      push_a(AW'(26 + i), $urandom);
      push_b(AW'(2 + i), $urandom);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    stim_a.delete();
    stim_b.delete();
    @(negedge clk);
    reset = 1'b0;
    wait_drain("reset_mid", 50);
    seen.delete();
    push_a(5'd7, 32'h7777_0007);
    push_b(5'd9, 32'h9999_0009);
    wait_drain("post_reset", 50);
    check("post_reset_count", 64'(seen.size()), 64'd2);
    if (seen.size() > 0) check("post_reset_first_grant", 64'(seen[0]), 64'd7);

    // Randomised traffic with gaps, random flushes and resets.
    gaps = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push_a(AW'($urandom), $urandom);
      push_b(AW'($urandom), $urandom);
    end
    rand_ctl = 1'b1;
    begin
      int n;
      n = 0;
      while ((stim_a.size() != 0 || stim_b.size() != 0) && n < 20000) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 20000) begin
        errors++;
        $display("FAIL random_timeout: sources not drained after %0d cycles", n);
      end
    end
    rand_ctl  = 1'b0;
    bus.flush = 1'b0;
    reset     = 1'b0;
    wait_drain("random_tail", 100);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
